// File: rtl/alert_pkg.sv
// alert_pkg: shared source indices, FSM state type and default timing for the alert scheduler.
package alert_pkg;
    localparam int SRC_FALL = 3;
    localparam int SRC_BPM  = 2;
    localparam int SRC_TEMP = 1;
    localparam int SRC_MED  = 0;
    localparam int HOLD_DEFAULT = 1000;
    localparam int ESC_DEFAULT  = 30000000;
    typedef enum logic [1:0] {S_IDLE, S_ALERT, S_ESC} state_e;
endpackage

// File: rtl/alert_scheduler_if.sv
// alert_scheduler_if: request/acknowledge inputs and annunciator outputs of the alert scheduler.
interface alert_scheduler_if;
    logic [3:0] req;
    logic       ack;
    logic       alert_active;
    logic [1:0] alert_src;
    logic       escalate;
    logic [3:0] pending;
    modport master (output req, ack, input alert_active, alert_src, escalate, pending);
    modport slave  (input req, ack, output alert_active, alert_src, escalate, pending);
endinterface

// File: rtl/alert_prio_enc.sv
// alert_prio_enc: fixed-priority select of the highest-index pending source (3 > 2 > 1 > 0).
module alert_prio_enc
    import alert_pkg::*;
(
    input  logic [3:0] pend_i,
    output logic [1:0] idx_o,
    output logic       valid_o
);
    assign valid_o = |pend_i;
    always_comb
        idx_o = pend_i[SRC_FALL] ? 2'(SRC_FALL) :
                pend_i[SRC_BPM]  ? 2'(SRC_BPM)  :
                pend_i[SRC_TEMP] ? 2'(SRC_TEMP) : 2'(SRC_MED);
endmodule

// File: rtl/alert_scheduler.sv
// alert_scheduler: latches rising alert requests, presents the highest-priority one on a shared
// annunciator, enforces a minimum hold before acknowledge and escalates unacknowledged alerts.
module alert_scheduler
    import alert_pkg::*;
#(
    parameter int HOLD_CYCLES = HOLD_DEFAULT,
    parameter int ESC_CYCLES  = ESC_DEFAULT
) (
    input logic              clk,
    input logic              reset,
    alert_scheduler_if.slave bus
);
    localparam int CW = $clog2(ESC_CYCLES + 1);

    state_e          state_q, state_d;
    logic [3:0]      req_q, pend_q, pend_d;
    logic [1:0]      src_q, src_d, top_idx;
    logic [CW-1:0]   hold_q, hold_d, esc_q, esc_d;
    logic            top_vld, ack_ok;

    alert_prio_enc u_enc (.pend_i(pend_q), .idx_o(top_idx), .valid_o(top_vld));

    assign ack_ok = bus.ack && state_q != S_IDLE && hold_q == CW'(HOLD_CYCLES);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            req_q   <= '0;
            pend_q  <= '0;
            src_q   <= '0;
            hold_q  <= '0;
            esc_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= bus.req;
            pend_q  <= pend_d;
            src_q   <= src_d;
            hold_q  <= hold_d;
            esc_q   <= esc_d;
        end
    end

    // A new request edge is ORed in after the ack clear, so a coincident edge wins.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        hold_d  = hold_q == CW'(HOLD_CYCLES) ? hold_q : hold_q + CW'(1);
        esc_d   = state_q == S_ALERT ? esc_q + CW'(1) : esc_q;
        pend_d  = (pend_q & ~(ack_ok ? 4'b0001 << src_q : 4'b0000)) | (bus.req & ~req_q);
        if (state_q == S_IDLE) begin
            hold_d = '0;
            esc_d  = '0;
            if (top_vld) begin
                state_d = S_ALERT;
                src_d   = top_idx;
            end
        end else if (ack_ok) begin
            state_d = S_IDLE;
        end else if (state_q == S_ALERT && top_idx > src_q) begin
            src_d  = top_idx;
            hold_d = '0;
            esc_d  = '0;
        end else if (state_q == S_ALERT && esc_q == CW'(ESC_CYCLES - 1)) begin
            state_d = S_ESC;
        end
    end

    always_comb begin
        bus.alert_active = state_q != S_IDLE;
        bus.alert_src    = state_q != S_IDLE ? src_q : 2'd0;
        bus.escalate     = state_q == S_ESC;
        bus.pending      = pend_q;
    end
endmodule
